// File: rtl/bp_me_xui_mem_arbiter_pkg.sv
// Shared message types and sizing for the XUI memory arbiter slice.
package bp_me_xui_mem_arbiter_pkg;

  localparam int unsigned paddr_width_p     = 40;
  localparam int unsigned cce_block_width_p = 512;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'b0000,
    e_bedrock_mem_wr    = 4'b0001,
    e_bedrock_mem_uc_rd = 4'b0010,
    e_bedrock_mem_uc_wr = 4'b0011
  } bp_bedrock_mem_type_e;

  typedef struct packed {
    logic [12:0]              payload;
    logic [2:0]               size;
    logic [paddr_width_p-1:0] addr;
    logic [3:0]               subop;
    bp_bedrock_mem_type_e     msg_type;
  } bp_bedrock_mem_header_s;

  typedef struct packed {
    logic [cce_block_width_p-1:0] data;
    bp_bedrock_mem_header_s       header;
  } bp_bedrock_mem_msg_s;

  localparam int unsigned cce_mem_msg_width_lp = $bits(bp_bedrock_mem_msg_s);

  // Index width that never collapses to zero bits.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/bp_me_xui_mem_arbiter_if.sv
// Requester-side and converter-side handshake bundle of the memory arbiter.
interface bp_me_xui_mem_arbiter_if
  import bp_me_xui_mem_arbiter_pkg::*;
#(
  parameter int unsigned num_req_p = 2
) ();

  logic [num_req_p*cce_mem_msg_width_lp-1:0] mem_cmd_i;
  logic [num_req_p-1:0]                      mem_cmd_v_i;
  logic [num_req_p-1:0]                      mem_cmd_ready_o;
  logic [num_req_p*cce_mem_msg_width_lp-1:0] mem_resp_o;
  logic [num_req_p-1:0]                      mem_resp_v_o;
  logic [num_req_p-1:0]                      mem_resp_yumi_i;
  logic [cce_mem_msg_width_lp-1:0]           mem_cmd_o;
  logic                                      mem_cmd_v_o;
  logic                                      mem_cmd_ready_i;
  logic [cce_mem_msg_width_lp-1:0]           mem_resp_i;
  logic                                      mem_resp_v_i;
  logic                                      mem_resp_yumi_o;

  modport slave (
    input  mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
    output mem_cmd_ready_o, mem_resp_o, mem_resp_v_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o
  );

  modport master (
    output mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i,
    input  mem_cmd_ready_o, mem_resp_o, mem_resp_v_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o
  );

endinterface

// File: rtl/bp_me_xui_mem_arbiter_rr_grant.sv
// Round-robin grant: first valid at or above the pointer, wrapping; pointer moves past the winner on advance.
module bp_me_xui_mem_arbiter_rr_grant
  import bp_me_xui_mem_arbiter_pkg::*;
#(
  parameter  int unsigned num_req_p = 2,
  localparam int unsigned lg_req_lp = safe_clog2(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_req_p-1:0] v_i,
  input  logic                 advance_i,
  output logic [lg_req_lp-1:0] grant_id_o,
  output logic                 v_o
);

  logic [lg_req_lp-1:0] ptr_q, ptr_d;
  int unsigned          idx;

  always_comb begin
    grant_id_o = ptr_q;
    v_o        = 1'b0;
    idx        = 0;
    for (int unsigned j = 0; j < num_req_p; j++) begin
      idx = (32'(ptr_q) + j) % num_req_p;
      if (!v_o && v_i[lg_req_lp'(idx)]) begin
        v_o        = 1'b1;
        grant_id_o = lg_req_lp'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = (grant_id_o == lg_req_lp'(num_req_p - 1)) ? '0 : grant_id_o + lg_req_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)        ptr_q <= '0;
    else if (advance_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bp_me_xui_mem_arbiter.sv
// Shares one CCE-MEM port among num_req_p requesters; an in-order tag FIFO routes responses back.
module bp_me_xui_mem_arbiter
  import bp_me_xui_mem_arbiter_pkg::*;
#(
  parameter  int unsigned num_req_p         = 2,
  parameter  int unsigned outstanding_els_p = 4,
  localparam int unsigned lg_req_lp         = safe_clog2(num_req_p),
  localparam int unsigned cnt_width_lp      = $clog2(outstanding_els_p + 1),
  localparam int unsigned ptr_width_lp      = safe_clog2(outstanding_els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bp_me_xui_mem_arbiter_if.slave  bus,
  output logic [cnt_width_lp-1:0] outstanding_o,
  output logic                    error_o
);

  localparam int unsigned msg_w_lp = cce_mem_msg_width_lp;

  logic [lg_req_lp-1:0]    winner, head;
  logic                    any_v, full, empty, push, pop;
  logic [ptr_width_lp-1:0] rd_ptr_q, wr_ptr_q;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic                    error_q;
  logic [lg_req_lp-1:0]    tag_mem_q [outstanding_els_p];

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(outstanding_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  bp_me_xui_mem_arbiter_rr_grant #(.num_req_p(num_req_p)) rr_grant (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (bus.mem_cmd_v_i),
    .advance_i  (push),
    .grant_id_o (winner),
    .v_o        (any_v)
  );

  // Full/empty come from the registered count only: a pop never frees a slot for a same-cycle push.
  assign full  = (count_q == cnt_width_lp'(outstanding_els_p));
  assign empty = (count_q == '0);
  assign head  = tag_mem_q[rd_ptr_q];

  assign bus.mem_cmd_v_o = any_v & ~full & ~reset_i;
  assign bus.mem_cmd_o   = bus.mem_cmd_i[32'(winner)*msg_w_lp +: msg_w_lp];
  assign push            = bus.mem_cmd_v_o & bus.mem_cmd_ready_i;

  always_comb begin
    bus.mem_cmd_ready_o         = '0;
    bus.mem_cmd_ready_o[winner] = bus.mem_cmd_ready_i & ~full & ~reset_i;
  end

  assign bus.mem_resp_o      = {num_req_p{bus.mem_resp_i}};
  assign bus.mem_resp_yumi_o = bus.mem_resp_yumi_i[head] & ~empty & ~reset_i;
  assign pop                 = bus.mem_resp_yumi_o;

  always_comb begin
    bus.mem_resp_v_o       = '0;
    bus.mem_resp_v_o[head] = bus.mem_resp_v_i & ~empty & ~reset_i;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + cnt_width_lp'(1);
      2'b01:   count_d = count_q - cnt_width_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
      error_q <= error_q | (bus.mem_resp_v_i & empty);
    end
  end

  // Tag storage needs no reset: entries are only read while the count says they are live.
  always_ff @(posedge clk_i) begin
    if (push) tag_mem_q[wr_ptr_q] <= winner;
  end

  assign outstanding_o = count_q;
  assign error_o       = error_q;

endmodule
